// File: rtl/arm_move_sequencer_if.sv
// rtl/arm_move_sequencer_if.sv - key, step and servo-move signal bundle for the arm move sequencer
interface arm_move_sequencer_if;
    logic       key_valid;
    logic [7:0] key_data;
    logic       step_tick;
    logic       move_ready;
    logic       move_valid;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic [7:0] tgt_x;
    logic [7:0] tgt_y;
    logic       busy;

    modport master (
        output key_valid, key_data, step_tick, move_ready,
        input  move_valid, pos_x, pos_y, tgt_x, tgt_y, busy
    );

    modport slave (
        input  key_valid, key_data, step_tick, move_ready,
        output move_valid, pos_x, pos_y, tgt_x, tgt_y, busy
    );
endinterface

// File: rtl/arm_move_sequencer.sv
// rtl/arm_move_sequencer.sv - keyboard-driven arm target tracker issuing one-unit servo moves per step tick
module arm_move_sequencer #(
    parameter int X_MAX  = 4,
    parameter int Y_MAX  = 4,
    parameter int X_INIT = 2,
    parameter int Y_INIT = 4
) (
    input  logic clk,
    input  logic reset,
    arm_move_sequencer_if.slave bus
);
    localparam logic [7:0] XM     = 8'(X_MAX);
    localparam logic [7:0] YM     = 8'(Y_MAX);
    localparam logic [7:0] X_HOME = 8'(X_INIT);
    localparam logic [7:0] Y_HOME = 8'(Y_INIT);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE} state_t;

    state_t     state;
    logic [7:0] pos_x, pos_y, tgt_x, tgt_y;
    logic [7:0] tgt_x_nx, tgt_y_nx;
    logic       move_valid, busy;
    logic       at_tgt, at_tgt_nx;

    // Saturating key decode; the registered target only changes on a valid key.
    always_comb begin
        tgt_x_nx = tgt_x;
        tgt_y_nx = tgt_y;
        if (bus.key_valid) begin
            case (bus.key_data)
                8'h77: if (tgt_y < YM)   tgt_y_nx = tgt_y + 8'd1;
                8'h73: if (tgt_y > 8'd1) tgt_y_nx = tgt_y - 8'd1;
                8'h61: if (tgt_x < XM)   tgt_x_nx = tgt_x + 8'd1;
                8'h64: if (tgt_x > 8'd1) tgt_x_nx = tgt_x - 8'd1;
                8'h68: begin
                    tgt_x_nx = X_HOME;
                    tgt_y_nx = Y_HOME;
                end
                default: ;
            endcase
        end
    end

    assign at_tgt    = (pos_x == tgt_x)    && (pos_y == tgt_y);
    assign at_tgt_nx = (pos_x == tgt_x_nx) && (pos_y == tgt_y_nx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pos_x      <= X_HOME;
            pos_y      <= Y_HOME;
            tgt_x      <= X_HOME;
            tgt_y      <= Y_HOME;
            move_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tgt_x <= tgt_x_nx;
            tgt_y <= tgt_y_nx;
            case (state)
                IDLE: begin
                    if (!at_tgt) begin
                        state <= WAIT_TICK;
                        busy  <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    // A target that moved back onto pos needs no step at all.
                    if (at_tgt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.step_tick) begin
                        if (pos_x != tgt_x)
                            pos_x <= (tgt_x > pos_x) ? pos_x + 8'd1 : pos_x - 8'd1;
                        else
                            pos_y <= (tgt_y > pos_y) ? pos_y + 8'd1 : pos_y - 8'd1;
                        state      <= ISSUE;
                        move_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.move_ready) begin
                        move_valid <= 1'b0;
                        if (at_tgt_nx) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    move_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.move_valid = move_valid;
    assign bus.busy       = busy;
    assign bus.pos_x      = pos_x;
    assign bus.pos_y      = pos_y;
    assign bus.tgt_x      = tgt_x;
    assign bus.tgt_y      = tgt_y;
endmodule

// File: tb/tb_arm_move_sequencer.sv
// tb/tb_arm_move_sequencer.sv - self-checking bench for arm_move_sequencer
module tb_arm_move_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_move_sequencer_if bus();
    arm_move_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {int x; int y;} pos_t;
    typedef struct {logic [7:0] key; int tx; int ty; bit settle;} vec_t;

    pos_t exp_q[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_cnt   = 0;
    int   tick_cnt = 0;
    bit   tick_en  = 0;
    bit   tick_man = 0;
    int   mx, my;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] k);
        bus.key_valid = 1'b1;
        bus.key_data  = k;
        cyc(1);
        bus.key_valid = 1'b0;
        bus.key_data  = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        exp_q.delete();
        mx = 2;
        my = 4;
    endtask

    task automatic push_path(input int tx, input int ty, output int steps);
        steps = 0;
        while (mx != tx) begin
            mx += (tx > mx) ? 1 : -1;
            exp_q.push_back('{mx, my});
            steps++;
        end
        while (my != ty) begin
            my += (ty > my) ? 1 : -1;
            exp_q.push_back('{mx, my});
            steps++;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget && (bus.busy || exp_q.size() != 0); i++) cyc(1);
        if (i >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d after %0d cycles", name, bus.busy, exp_q.size(), budget);
        end
    endtask

    task automatic wait_mv(input string name, input int budget);
        int i;
        for (i = 0; i < budget && !bus.move_valid; i++) cyc(1);
        check({name, "_mv_seen"}, int'(bus.move_valid), 1);
    endtask

    task automatic check_pos(input string name, input int x, input int y);
        check({name, "_pos_x"}, int'(bus.pos_x), x);
        check({name, "_pos_y"}, int'(bus.pos_y), y);
    endtask

    task automatic check_tgt(input string name, input int x, input int y);
        check({name, "_tgt_x"}, int'(bus.tgt_x), x);
        check({name, "_tgt_y"}, int'(bus.tgt_y), y);
    endtask

    initial begin
        bus.step_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt++;
            bus.step_tick = (tick_en && (tick_cnt % 16 == 0)) || tick_man;
        end
    end

    // Scoreboard: every completed handshake must match the next expected position.
    initial begin
        pos_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.move_valid && bus.move_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_move: got pos=(%0d,%0d), expected no move", bus.pos_x, bus.pos_y);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_move_x", int'(bus.pos_x), e.x);
                    check("sb_move_y", int'(bus.pos_y), e.y);
                end
            end
        end
    end

    initial begin
        int hs0, steps, bad, busy_seen, ticks0;

        vecs[0]  = '{8'h77, 2, 4, 1'b0};
        vecs[1]  = '{8'h64, 1, 4, 1'b0};
        vecs[2]  = '{8'h64, 1, 4, 1'b1};
        vecs[3]  = '{8'h61, 2, 4, 1'b0};
        vecs[4]  = '{8'h61, 3, 4, 1'b0};
        vecs[5]  = '{8'h61, 4, 4, 1'b0};
        vecs[6]  = '{8'h61, 4, 4, 1'b1};
        vecs[7]  = '{8'h73, 4, 3, 1'b0};
        vecs[8]  = '{8'h78, 4, 3, 1'b0};
        vecs[9]  = '{8'h73, 4, 2, 1'b0};
        vecs[10] = '{8'h73, 4, 1, 1'b0};
        vecs[11] = '{8'h73, 4, 1, 1'b1};
        vecs[12] = '{8'h68, 2, 4, 1'b0};
        vecs[13] = '{8'h57, 2, 4, 1'b1};
        vecs[14] = '{8'h64, 1, 4, 1'b0};
        vecs[15] = '{8'h73, 1, 3, 1'b1};

        bus.key_valid  = 1'b0;
        bus.key_data   = 8'h00;
        bus.move_ready = 1'b1;
        reset          = 1'b1;
        cyc(3);
        do_reset();

        check_pos("reset", 2, 4);
        check_tgt("reset", 2, 4);
        check("reset_move_valid", int'(bus.move_valid), 0);
        check("reset_busy", int'(bus.busy), 0);

        tick_en   = 1;
        hs0       = hs_cnt;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.busy || bus.move_valid) busy_seen++;
        end
        check("idle_quiet_cycles", busy_seen, 0);
        check("idle_handshakes", hs_cnt - hs0, 0);

        // Single 'a' step: busy latency and a single handshake.
        tick_en = 0;
        do_reset();
        hs0 = hs_cnt;
        press(8'h61);
        check_tgt("a_key", 3, 4);
        check("a_busy_at_key_edge", int'(bus.busy), 0);
        cyc(1);
        check("a_busy_one_later", int'(bus.busy), 1);
        push_path(3, 4, steps);
        tick_en = 1;
        wait_idle("a_move", 200);
        check_pos("a_done", 3, 4);
        check("a_handshakes", hs_cnt - hs0, 1);
        check("a_busy_done", int'(bus.busy), 0);

        // Back-to-back 'a','s'.
        tick_en = 0;
        do_reset();
        hs0 = hs_cnt;
        press(8'h61);
        press(8'h73);
        check_tgt("as_key", 3, 3);
        push_path(3, 3, steps);
        tick_en = 1;
        wait_idle("as_move", 200);
        check_pos("as_done", 3, 3);
        check("as_handshakes", hs_cnt - hs0, 2);

        // Table of keys with saturation; settle rows run the moves to completion.
        tick_en = 0;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            press(vecs[v].key);
            check($sformatf("vec%0d_tgt_x", v), int'(bus.tgt_x), vecs[v].tx);
            check($sformatf("vec%0d_tgt_y", v), int'(bus.tgt_y), vecs[v].ty);
            if (vecs[v].settle) begin
                hs0 = hs_cnt;
                push_path(vecs[v].tx, vecs[v].ty, steps);
                tick_en = 1;
                wait_idle($sformatf("vec%0d", v), 400);
                tick_en = 0;
                check($sformatf("vec%0d_pos_x", v), int'(bus.pos_x), vecs[v].tx);
                check($sformatf("vec%0d_pos_y", v), int'(bus.pos_y), vecs[v].ty);
                check($sformatf("vec%0d_handshakes", v), hs_cnt - hs0, steps);
            end
        end

        // Key and tick in the same WAIT_TICK cycle: step uses the old target.
        do_reset();
        hs0 = hs_cnt;
        press(8'h61);
        cyc(2);
        check("kt_busy", int'(bus.busy), 1);
        push_path(3, 4, steps);
        push_path(2, 4, steps);
        tick_man      = 1;
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h64;
        cyc(1);
        tick_man      = 0;
        bus.key_valid = 1'b0;
        check_pos("kt_step", 3, 4);
        check_tgt("kt_step", 2, 4);
        tick_en = 1;
        wait_idle("kt_move", 200);
        tick_en = 0;
        check_pos("kt_done", 2, 4);
        check("kt_handshakes", hs_cnt - hs0, 2);

        // 40-cycle stall in ISSUE with a home key and ticks arriving meanwhile.
        do_reset();
        bus.move_ready = 1'b0;
        press(8'h61);
        press(8'h61);
        tick_en = 1;
        wait_mv("stall", 60);
        check_pos("stall_start", 3, 4);
        bad    = 0;
        ticks0 = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) begin
                bus.key_valid = 1'b1;
                bus.key_data  = 8'h68;
            end else begin
                bus.key_valid = 1'b0;
            end
            cyc(1);
            if (bus.step_tick) ticks0++;
            if (!bus.move_valid || bus.pos_x != 8'd3 || bus.pos_y != 8'd4) bad++;
        end
        bus.key_valid = 1'b0;
        check("stall_hold_violations", bad, 0);
        check("stall_ticks_present", int'(ticks0 >= 2), 1);
        check_tgt("stall_home", 2, 4);
        hs0 = hs_cnt;
        mx  = 2;
        my  = 4;
        exp_q.push_back('{3, 4});
        exp_q.push_back('{2, 4});
        bus.move_ready = 1'b1;
        wait_idle("stall_release", 200);
        check_pos("stall_done", 2, 4);
        check("stall_handshakes", hs_cnt - hs0, 2);

        // Reset while ISSUE is stalled, then reset racing a key.
        tick_en = 0;
        do_reset();
        bus.move_ready = 1'b0;
        press(8'h61);
        tick_en = 1;
        wait_mv("rst_issue", 60);
        reset = 1'b1;
        cyc(1);
        check("rst_issue_move_valid", int'(bus.move_valid), 0);
        check("rst_issue_busy", int'(bus.busy), 0);
        check_pos("rst_issue", 2, 4);
        check_tgt("rst_issue", 2, 4);
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h61;
        cyc(1);
        bus.key_valid = 1'b0;
        reset = 1'b0;
        check_tgt("rst_key_prio", 2, 4);
        tick_en        = 0;
        bus.move_ready = 1'b1;
        exp_q.delete();
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
